// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: opcodes, class codes,
// FSM states, the latched request record and the request legality check.
package instr_encoder_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] CLS_R   = 3'd0;
    localparam logic [2:0] CLS_I   = 3'd1;
    localparam logic [2:0] CLS_LW  = 3'd2;
    localparam logic [2:0] CLS_SW  = 3'd3;
    localparam logic [2:0] CLS_BEQ = 3'd4;

    localparam logic [2:0]  F3_WORD  = 3'b010;
    localparam logic [2:0]  F3_BEQ   = 3'b000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [12:0] imm;
    } req_t;

    // Only add/sub and srl/sra have a funct7b5 variant; branch targets are halfword aligned.
    function automatic logic req_illegal(req_t r);
        return (r.cls > CLS_BEQ) ||
               (r.cls == CLS_R && r.funct7b5 && r.funct3 != 3'b000 && r.funct3 != 3'b101) ||
               (r.cls == CLS_BEQ && r.imm[0]);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request handshake and instruction-memory write bus of the encoder.
// master = request source / memory side, slave = the encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              inValid;
    logic              inReady;
    logic [2:0]        inClass;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic [12:0]       imm;
    logic              flush;
    logic              memWe;
    logic [ADDR_W+1:0] memAddr;
    logic [31:0]       memWdata;
    logic [ADDR_W:0]   wrCount;
    logic              full;
    logic              err;

    modport master (
        output inValid, inClass, rd, rs1, rs2, funct3, funct7b5, imm, flush,
        input  inReady, memWe, memAddr, memWdata, wrCount, full, err
    );

    modport slave (
        input  inValid, inClass, rd, rs1, rs2, funct3, funct7b5, imm, flush,
        output inReady, memWe, memAddr, memWdata, wrCount, full, err
    );

endinterface

// File: rtl/instr_pack.sv
// Combinational packer: request class + fields -> 32-bit RV32I instruction word.
// Illegal classes pack to the canonical NOP (addi x0,x0,0).
module instr_pack
    import instr_encoder_pkg::*;
(
    input  req_t        req,
    output logic [31:0] word
);

    // Branch offsets are always even, so bit 0 never reaches the word.
    logic unused_imm0;
    assign unused_imm0 = req.imm[0];

    always_comb begin
        word = NOP_WORD;
        case (req.cls)
            CLS_R:   word = {1'b0, req.funct7b5, 5'b0, req.rs2, req.rs1, req.funct3, req.rd, OP_R};
            CLS_I:   word = {req.imm[11:0], req.rs1, req.funct3, req.rd, OP_I};
            CLS_LW:  word = {req.imm[11:0], req.rs1, F3_WORD, req.rd, OP_LOAD};
            CLS_SW:  word = {req.imm[11:5], req.rs2, req.rs1, F3_WORD, req.imm[4:0], OP_STORE};
            CLS_BEQ: word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, F3_BEQ,
                             req.imm[4:1], req.imm[11], OP_BRANCH};
            default: word = NOP_WORD;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I encoder / program loader: accept a request, encode it, write it to
// the next instruction-memory word. Define ENC_ERR_CHECK_EN to reject malformed requests.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            resetN,
    instr_encoder_if.slave  bus
);

    localparam logic [ADDR_W+1:0] BASE  = BASE_ADDR[ADDR_W+1:0];
    localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_e            state, state_nx;
    req_t              req, req_in;
    logic [31:0]       word_c;
    logic [31:0]       mem_wdata;
    logic [ADDR_W+1:0] mem_addr;
    logic [ADDR_W:0]   wr_count;
    logic              is_full;
    logic              hs;
    logic              bad_c, bad_q;

    assign req_in = '{cls: bus.inClass, rd: bus.rd, rs1: bus.rs1, rs2: bus.rs2,
                      funct3: bus.funct3, funct7b5: bus.funct7b5, imm: bus.imm};

    assign is_full = (wr_count == DEPTH);
    assign hs      = bus.inValid && bus.inReady;

    instr_pack u_pack (
        .req  (req),
        .word (word_c)
    );

`ifdef ENC_ERR_CHECK_EN
    assign bad_c = req_illegal(req);
`else
    assign bad_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= ST_IDLE;
        else         state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (hs) state_nx = ST_ENC;
            ST_ENC:  state_nx = ST_WR;
            ST_WR:   state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output logic; flush blocks the handshake so it always wins over inValid.
    always_comb begin
        bus.inReady = (state == ST_IDLE) && !is_full && !bus.flush;
        bus.memWe   = (state == ST_WR) && !bad_q;
`ifdef ENC_ERR_CHECK_EN
        bus.err     = (state == ST_WR) && bad_q;
`else
        bus.err     = 1'b0;
`endif
    end

    assign bus.memAddr  = mem_addr;
    assign bus.memWdata = mem_wdata;
    assign bus.wrCount  = wr_count;
    assign bus.full     = is_full;

    // Datapath: request latch, encoded word, write address and write counter.
    // The counter doubles as the write pointer; it stops at DEPTH and never wraps.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            req       <= '0;
            bad_q     <= 1'b0;
            mem_wdata <= '0;
            mem_addr  <= BASE;
            wr_count  <= '0;
        end else begin
            if (hs) req <= req_in;
            if (state == ST_ENC) begin
                bad_q <= bad_c;
                if (!bad_c) begin
                    mem_wdata <= word_c;
                    mem_addr  <= BASE + {wr_count[ADDR_W-1:0], 2'b00};
                end
            end
            if (state == ST_IDLE && bus.flush)
                wr_count <= '0;
            else if (state == ST_WR && !bad_q)
                wr_count <= wr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboarded bench for instr_encoder: driver pushes expected writes, a negedge monitor
// pops and compares every memWe; reference encoding is done with plain field arithmetic.
module tb_instr_encoder;

    localparam int AW    = 6;
    localparam int BASE  = 0;
    localparam int DEPTH = 1 << AW;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(AW)) bus();

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          model_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference encoder built from the field placement rules with shifts and masks.
    function automatic logic [31:0] ref_word(input logic [2:0] c, input logic [4:0] d, s1, s2,
                                             input logic [2:0] f3, input logic f7,
                                             input logic [12:0] im);
        int unsigned u  = 32'(im);
        int unsigned D  = 32'(d);
        int unsigned S1 = 32'(s1);
        int unsigned S2 = 32'(s2);
        int unsigned F3 = 32'(f3);
        int unsigned F7 = 32'(f7);
        case (c)
            3'd0: return (F7 << 30) | (S2 << 20) | (S1 << 15) | (F3 << 12) | (D << 7) | 32'd51;
            3'd1: return ((u % 4096) << 20) | (S1 << 15) | (F3 << 12) | (D << 7) | 32'd19;
            3'd2: return ((u % 4096) << 20) | (S1 << 15) | (32'd2 << 12) | (D << 7) | 32'd3;
            3'd3: return (((u / 32) % 128) << 25) | (S2 << 20) | (S1 << 15) | (32'd2 << 12)
                         | ((u % 32) << 7) | 32'd35;
            3'd4: return (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) | (S2 << 20)
                         | (S1 << 15) | (((u / 2) % 16) << 8) | (((u / 2048) % 2) << 7) | 32'd99;
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic bit ref_flag(input logic [2:0] c, input logic [2:0] f3, input logic f7,
                                    input logic [12:0] im);
`ifdef ENC_ERR_CHECK_EN
        return (c >= 3'd5) || (c == 3'd0 && f7 && f3 != 3'd0 && f3 != 3'd5) ||
               (c == 3'd4 && im[0]);
`else
        return 1'b0 & (c[0] ^ f3[0] ^ f7 ^ im[0]);
`endif
    endfunction

    // Monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetN && bus.memWe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0h data=%08h expected none @%0t",
                         bus.memAddr, bus.memWdata, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.memAddr), mon_e[63:32]);
                chk("wr_data", bus.memWdata, mon_e[31:0]);
            end
        end
    end

    task automatic drive(input logic [2:0] c, input logic [4:0] d, s1, s2,
                         input logic [2:0] f3, input logic f7, input logic [12:0] im);
        bus.inClass = c; bus.rd = d; bus.rs1 = s1; bus.rs2 = s2;
        bus.funct3 = f3; bus.funct7b5 = f7; bus.imm = im;
    endtask

    // One request: handshake, push expectation, check latency/err and return to ready.
    task automatic send(input logic [2:0] c, input logic [4:0] d, s1, s2,
                        input logic [2:0] f3, input logic f7, input logic [12:0] im,
                        input bit use_lit, input logic [31:0] lit);
        int n;
        int lat;
        bit flag;
        @(negedge clk);
        drive(c, d, s1, s2, f3, f7, im);
        bus.inValid = 1'b1;
        n = 0;
        while (!bus.inReady && n < 20) begin @(negedge clk); n++; end
        if (!bus.inReady) begin
            chk("handshake_timeout", 32'(bus.inReady), 32'd1);
            bus.inValid = 1'b0;
            return;
        end
        flag = ref_flag(c, f3, f7, im);
        if (!flag) begin
            exp_q.push_back({32'(BASE + 4 * model_cnt), use_lit ? lit : ref_word(c, d, s1, s2, f3, f7, im)});
            model_cnt++;
        end
        @(posedge clk);
        #1 bus.inValid = 1'b0;
        lat = 0;
        while (lat < 6) begin
            @(negedge clk);
            lat++;
            if (bus.memWe || bus.err) break;
        end
        if (flag) begin
            chk("err_pulse", 32'(bus.err), 32'd1);
            chk("err_no_we", 32'(bus.memWe), 32'd0);
        end else begin
            chk("wr_latency", 32'(lat), 32'd2);
        end
        @(negedge clk);
        chk("ready_after_wr", 32'(bus.inReady), 32'(model_cnt < DEPTH));
        chk("wr_count", 32'(bus.wrCount), 32'(model_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.inValid = 1'b0;
        bus.flush   = 1'b0;
        drive(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_memWe", 32'(bus.memWe), 32'd0);
        chk("rst_wrCount", 32'(bus.wrCount), 32'd0);
        chk("rst_memAddr", 32'(bus.memAddr), 32'(BASE));
        chk("rst_memWdata", bus.memWdata, 32'd0);
        chk("rst_inReady", 32'(bus.inReady), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        resetN = 1'b1;

        // Directed encodings with hand-derived words
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0, 1'b1, 32'h002081B3);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'd0, 1'b1, 32'h402081B3);
        send(3'd3, 5'd0, 5'd2, 5'd5, 3'd0, 1'b0, 13'd8, 1'b1, 32'h00512423);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h1FF8, 1'b1, 32'hFE208CE3);
        send(3'd2, 5'd4, 5'd1, 5'd0, 3'd7, 1'b0, 13'h1FFC, 1'b1, 32'hFFC0A203);
        send(3'd6, 5'd9, 5'd9, 5'd9, 3'd5, 1'b1, 13'h0AAA, 1'b1, 32'h00000013);

        // Randomized requests, all classes, random gaps
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 1'($urandom), 13'($urandom), 1'b0, 32'd0);
        end

        // Fill to capacity
        for (int k = 0; k < DEPTH && model_cnt < DEPTH; k++)
            send(3'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 1'b0, 13'($urandom), 1'b0, 32'd0);
        @(negedge clk);
        chk("full_flag", 32'(bus.full), 32'd1);
        chk("full_inReady", 32'(bus.inReady), 32'd0);
        chk("full_wrCount", 32'(bus.wrCount), 32'(DEPTH));
        bus.inValid = 1'b1;
        repeat (8) @(negedge clk);
        chk("full_no_accept", 32'(bus.inReady), 32'd0);
        chk("full_hold_count", 32'(bus.wrCount), 32'(DEPTH));

        // Flush while full (inValid still high): no handshake, pointer cleared
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        bus.inValid = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        chk("flush_wrCount", 32'(bus.wrCount), 32'd0);
        chk("flush_full", 32'(bus.full), 32'd0);
        chk("flush_inReady", 32'(bus.inReady), 32'd1);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0, 1'b1, 32'h002081B3);
        send(3'd1, 5'd7, 5'd6, 5'd0, 3'd4, 1'b0, 13'h0123, 1'b0, 32'd0);

        // flush and inValid together when not full: flush wins
        @(negedge clk);
        drive(3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 13'd5);
        bus.flush = 1'b1;
        bus.inValid = 1'b1;
        #1 chk("flush_blocks_ready", 32'(bus.inReady), 32'd0);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        bus.inValid = 1'b0;
        model_cnt = 0;
        repeat (3) @(negedge clk);
        chk("flush_valid_count", 32'(bus.wrCount), 32'd0);
        chk("flush_valid_ready", 32'(bus.inReady), 32'd1);
        send(3'd2, 5'd4, 5'd1, 5'd0, 3'd0, 1'b0, 13'h1FFC, 1'b1, 32'hFFC0A203);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 13'd0, 1'b1, 32'h002081B3);

        // Reset during ENC aborts the request
        @(negedge clk);
        drive(3'd3, 5'd0, 5'd2, 5'd5, 3'd0, 1'b0, 13'd8);
        bus.inValid = 1'b1;
        @(posedge clk);
        #1 bus.inValid = 1'b0;
        resetN = 1'b0;
        @(negedge clk);
        chk("abort_memWe", 32'(bus.memWe), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        model_cnt = 0;
        repeat (2) @(negedge clk);
        chk("abort_wrCount", 32'(bus.wrCount), 32'd0);
        chk("abort_memAddr", 32'(bus.memAddr), 32'(BASE));
        chk("abort_inReady", 32'(bus.inReady), 32'd1);
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 13'h1FF8, 1'b1, 32'hFE208CE3);

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
